chart_sequencer: RTL and testbench

//  Tempo-driven address generator and note emitter upstream of the chart ROM; drives rd_addr_o, samples the ROM's

---
 rtl/chart_sequencer.sv | 154 +++++++++++++++
 tb/tb_chart_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/chart_sequencer.sv
// Tempo-driven chart ROM address generator and note emitter with valid/ready output.
// Define CHART_LOOP_EN to wrap to address 0 after the last entry instead of finishing.
module chart_sequencer #(
  parameter int unsigned          width_p          = 8,
  parameter int unsigned          depth_p          = 8,
  parameter int unsigned          ticks_per_step_p = 1_500_000,
  parameter logic [width_p-1:0]   end_marker_p     = 8'hFF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic                       pause_i,
  output logic [$clog2(depth_p)-1:0] rd_addr_o,
  input  logic [width_p-1:0]         rd_data_i,
  output logic [width_p-1:0]         note_o,
  output logic                       note_valid_o,
  input  logic                       note_ready_i,
  output logic                       playing_o,
  output logic                       done_o,
  output logic                       overrun_o
);

  localparam int unsigned addr_w_lp = $clog2(depth_p);
  localparam int unsigned cnt_w_lp  = $clog2(ticks_per_step_p);
  localparam logic [addr_w_lp-1:0] addr_last_lp = addr_w_lp'(depth_p - 1);
  localparam logic [cnt_w_lp-1:0]  cnt_last_lp  = cnt_w_lp'(ticks_per_step_p - 1);

`ifdef CHART_LOOP_EN
  localparam bit loop_en_lp = 1'b1;
`else
  localparam bit loop_en_lp = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, EMIT, DONE} state_e;

  state_e                 state_q, state_d;
  logic [cnt_w_lp-1:0]    cnt_q, cnt_d;
  logic [addr_w_lp-1:0]   addr_q, addr_d;
  logic [width_p-1:0]     note_q, note_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;
  logic                   playing_q, playing_d;
  logic                   done_q, done_d;

  logic running;
  logic step;
  logic handshake;
  logic last_addr;
  logic is_end;

  assign running   = (state_q == WAIT) || (state_q == EMIT);
  assign step      = running && !pause_i && (cnt_q == cnt_last_lp);
  assign handshake = valid_q && note_ready_i;
  assign last_addr = (addr_q == addr_last_lp);
  assign is_end    = (rd_data_i == end_marker_p);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: if (start_i) state_d = WAIT;
        WAIT: if (step) state_d = is_end ? DONE : EMIT;
        EMIT: if (handshake) state_d = (last_addr && !loop_en_lp) ? DONE : WAIT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    note_d    = note_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (running && !pause_i) begin
      cnt_d = (cnt_q == cnt_last_lp) ? '0 : cnt_q + 1'b1;
    end
    if (stop_i) begin
      valid_d = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            addr_d    = '0;
            cnt_d     = '0;
            overrun_d = 1'b0;
          end
        end
        WAIT: begin
          if (step && !is_end) begin
            note_d  = rd_data_i;
            valid_d = 1'b1;
          end
        end
        EMIT: begin
          // A step coinciding with acceptance is simply absorbed; otherwise it is lost.
          if (handshake) begin
            valid_d = 1'b0;
            if (!last_addr) begin
              addr_d = addr_q + 1'b1;
            end else if (loop_en_lp) begin
              addr_d = '0;
            end
          end else if (step) begin
            overrun_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    playing_d = (state_d == WAIT) || (state_d == EMIT);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      addr_q    <= '0;
      note_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      note_q    <= note_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      playing_q <= playing_d;
      done_q    <= done_d;
    end
  end

  assign rd_addr_o    = addr_q;
  assign note_o       = note_q;
  assign note_valid_o = valid_q;
  assign playing_o    = playing_q;
  assign done_o       = done_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_chart_sequencer.sv
// Self-checking bench for chart_sequencer: directed timeline checks plus randomized play
// compared every cycle against a behavioural model of the playback rules.
module tb_chart_sequencer;

  localparam int TPS = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0, ready = 1'b0;
  logic [2:0] rd_addr;
  logic [7:0] rd_data, note;
  logic       note_valid, playing, done, overrun;
  logic [7:0] rom [DEPTH];

  int n_checks = 0;
  int n_fail = 0;
  int t = 0;
  bit cmp_en = 1'b0;

  // behavioural model: 0 idle, 1 waiting for step, 2 presenting note, 3 finished
  int         m_state = 0;
  int         m_tick = 0;
  int         m_addr = 0;
  logic [7:0] m_note = '0;
  bit         m_valid = 0, m_over = 0;

  always #5 clk = ~clk;

  assign rd_data = rom[rd_addr];

  chart_sequencer #(
    .width_p(8), .depth_p(DEPTH), .ticks_per_step_p(TPS), .end_marker_p(8'hFF)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop), .pause_i(pause),
    .rd_addr_o(rd_addr), .rd_data_i(rd_data), .note_o(note), .note_valid_o(note_valid),
    .note_ready_i(ready), .playing_o(playing), .done_o(done), .overrun_o(overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_update();
    bit st, hs, playing_now;
    if (!rst_n) begin
      m_state = 0; m_tick = 0; m_addr = 0; m_note = '0; m_valid = 0; m_over = 0;
      return;
    end
    playing_now = (m_state == 1) || (m_state == 2);
    st = playing_now && !pause && (m_tick == TPS - 1);
    hs = m_valid && ready;
    if (playing_now && !pause) m_tick = (m_tick + 1) % TPS;
    if (stop) begin
      m_state = 0; m_valid = 0; m_tick = 0;
      return;
    end
    case (m_state)
      0, 3: if (start) begin m_state = 1; m_addr = 0; m_tick = 0; m_over = 0; end
      1: if (st) begin
        if (rom[m_addr] == 8'hFF) m_state = 3;
        else begin m_note = rom[m_addr]; m_valid = 1; m_state = 2; end
      end
      default: begin
        if (hs) begin
          m_valid = 0;
          if (m_addr < DEPTH - 1) begin m_addr++; m_state = 1; end
`ifdef CHART_LOOP_EN
          else begin m_addr = 0; m_state = 1; end
`else
          else m_state = 3;
`endif
        end else if (st) m_over = 1;
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_update();
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_rd_addr", 32'(rd_addr), 32'(m_addr));
      chk("cmp_valid", 32'(note_valid), 32'(m_valid));
      chk("cmp_playing", 32'(playing), 32'((m_state == 1) || (m_state == 2)));
      chk("cmp_done", 32'(done), 32'(m_state == 3));
      chk("cmp_overrun", 32'(overrun), 32'(m_over));
      if (m_valid) chk("cmp_note", 32'(note), 32'(m_note));
    end
  end

  task automatic adv(input int n);
    repeat (n) begin @(posedge clk); #1; t++; end
  endtask

  task automatic go_start();
    start = 1'b1; @(posedge clk); #1; start = 1'b0; t = 1;
  endtask

  task automatic to_idle();
    stop = 1'b1; @(posedge clk); #1; stop = 1'b0;
  endtask

  task automatic at(input int k);
    adv(k - t); @(negedge clk);
  endtask

  initial begin
    bit found;
    int mode;
    logic [7:0] base [DEPTH];
    base = '{8'h01, 8'h02, 8'h04, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    rom = base;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(note_valid), 0);
    chk("rst_playing", 32'(playing), 0);
    chk("rst_addr", 32'(rd_addr), 0);
    @(posedge clk); #1; rst_n = 1'b1; cmp_en = 1'b1;
    adv(2);

    // basic playback timeline
    ready = 1'b1; go_start();
    at(4); chk("t2_t4_valid", 32'(note_valid), 0);
    at(5); chk("t2_t5_valid", 32'(note_valid), 1); chk("t2_t5_note", 32'(note), 32'h01);
    at(9); chk("t2_t9_valid", 32'(note_valid), 1); chk("t2_t9_note", 32'(note), 32'h02);
    at(13); chk("t2_t13_note", 32'(note), 32'h04); chk("t2_t13_valid", 32'(note_valid), 1);
    at(16); chk("t2_t16_done", 32'(done), 0);
    at(17); chk("t2_t17_done", 32'(done), 1); chk("t2_overrun", 32'(overrun), 0);
    chk("t2_addr", 32'(rd_addr), 3); chk("t2_playing", 32'(playing), 0);

    // stall causes overrun, note held
    ready = 1'b0; go_start();
    at(8); chk("t3_t8_overrun", 32'(overrun), 0);
    at(9); chk("t3_t9_overrun", 32'(overrun), 1); chk("t3_t9_note", 32'(note), 32'h01);
    at(12); chk("t3_t12_note", 32'(note), 32'h01); chk("t3_t12_valid", 32'(note_valid), 1);
    adv(13 - t); ready = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      adv(1); @(negedge clk);
      if (note_valid) begin
        found = 1;
        chk("t3_next_note", 32'(note), 32'h02);
        chk("t3_next_time", 32'(t), 17);
      end
    end
    if (!found) chk("t3_timeout", 0, 1);
    to_idle();

    // pause during WAIT delays by exactly the pause length
    go_start();
    adv(6 - t); pause = 1'b1;
    adv(10); pause = 1'b0;
    at(18); chk("t4_t18_valid", 32'(note_valid), 0);
    at(19); chk("t4_t19_valid", 32'(note_valid), 1); chk("t4_t19_note", 32'(note), 32'h02);
    to_idle();

    // no end marker: full chart
    for (int i = 0; i < DEPTH; i++) rom[i] = 8'h11;
    go_start();
    at(33); chk("t5_t33_valid", 32'(note_valid), 1); chk("t5_t33_addr", 32'(rd_addr), 7);
`ifdef CHART_LOOP_EN
    at(37); chk("t5_loop_valid", 32'(note_valid), 1); chk("t5_loop_addr", 32'(rd_addr), 0);
    chk("t5_loop_done", 32'(done), 0);
`else
    at(34); chk("t5_done", 32'(done), 1); chk("t5_addr", 32'(rd_addr), 7);
    chk("t5_valid", 32'(note_valid), 0);
`endif
    to_idle();

    // stop during EMIT, then replay
    rom = base; ready = 1'b0; go_start();
    at(10); chk("t6_overrun_pre", 32'(overrun), 1);
    adv(0); stop = 1'b1; adv(1); stop = 1'b0;
    @(negedge clk);
    chk("t6_valid", 32'(note_valid), 0); chk("t6_playing", 32'(playing), 0);
    chk("t6_overrun_kept", 32'(overrun), 1);
    go_start(); @(negedge clk);
    chk("t6_restart_overrun", 32'(overrun), 0); chk("t6_restart_addr", 32'(rd_addr), 0);
    chk("t6_restart_playing", 32'(playing), 1);

    // asynchronous reset mid-EMIT
    at(6); chk("t1_pre_valid", 32'(note_valid), 1);
    @(posedge clk); #3; rst_n = 1'b0; #1;
    chk("t1_valid", 32'(note_valid), 0); chk("t1_playing", 32'(playing), 0);
    chk("t1_note", 32'(note), 0); chk("t1_overrun", 32'(overrun), 0);
    chk("t1_addr", 32'(rd_addr), 0); chk("t1_done", 32'(done), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    adv(5); @(negedge clk);
    chk("t1_idle_playing", 32'(playing), 0); chk("t1_idle_valid", 32'(note_valid), 0);

    // randomized play against the model
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (c % 64 == 0) mode = $urandom_range(0, 1);
      ready = (mode == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 3);
      pause = ($urandom_range(0, 15) == 0);
      stop  = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 9) == 0);
      if (start && (m_state == 0 || m_state == 3)) begin
        for (int i = 0; i < DEPTH; i++)
          rom[i] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      end
    end
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0; pause = 1'b0; ready = 1'b0;
    adv(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
